alu_mdu: RTL and testbench
==========================

# alu_mdu

Parametrised execute unit for the RV32IM datapath: decodes opcode/funct3/funct7 itself and computes base integer ALU ops in one cycle and M-extension multiply/divide/remainder iteratively over XLEN cycles. It sits in the execute stage between register read and writeback. The core stalls on `ready_o` low. Compared with the single-cycle decoder path, it adds SRA, SLTU, AUIPC/LUI handling, an illegal-op flag and a valid/ready handshake.

## Interface
- `XLEN`, default 32: operand and result width; must be ≥ 8 and a power of two.
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `valid_i` input 1: request present.
- `ready_o` output 1: unit idle and able to accept; reset value 1.
- `opcode` input 7: instruction opcode.
- `funct3` input 3: instruction funct3.
- `funct7` input 7: instruction funct7.
- `a` input XLEN: operand A (rs1 or PC).
- `b` input XLEN: operand B (rs2 or immediate).
- `result` output XLEN: registered result, held until next completion; reset value 0.
- `result_valid` output 1: one-cycle completion pulse; reset value 0.
- `illegal_o` output 1: asserted with `result_valid` for undecodable ops; reset value 0.

## Operation
- Accept when `valid_i && ready_o` at a rising edge. Inputs are sampled only then.
- Decode, by opcode:
  - 0110011, funct7 0000000 / 0100000: ADD/SUB, SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND.
  - 0110011, funct7 0000001: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU (by funct3).
  - 0010011: ADDI..ANDI. SRAI when funct3=101 and funct7=0100000; SLLI/SRLI/SRAI with any other funct7 bits → illegal.
  - 0000011, 0100011, 0010111 (AUIPC): ADD.
  - 1100011: SUB.
  - 0110111 (LUI): pass `b`.
  - Anything else: ADD, `illegal_o`=1.
- Shift amount is `b[$clog2(XLEN)-1:0]`. SLT is signed; SLTU is unsigned. Result is 0/1 zero-extended.
- Multiply: operand magnitudes, unsigned shift-add into a 2·XLEN accumulator, one bit per cycle. Negate at the end if the signs differ (MULHSU treats B as unsigned). MUL returns the low half; MULH* return the high half.
- Divide: restoring, on magnitudes, one quotient bit per cycle. Sign fix at the end: the quotient is negative if the signs differ, and the remainder takes the dividend's sign.
- Divide by zero: quotient all-ones; remainder equals the dividend (signed and unsigned).
- Signed overflow (most-negative ÷ −1): quotient equals the dividend; remainder 0.
- Special cases still take full M latency; there is no early exit.
- FSM:
  - IDLE → (accept M op) LOAD → BUSY (XLEN cycles, counter XLEN−1 down to 0) → FIX → IDLE.
  - Base ops never leave IDLE.
  - `ready_o` = (state==IDLE).
- `valid_i` during LOAD/BUSY/FIX is ignored, with no queuing.
- Reset at any time: state IDLE, counter and accumulators cleared, `result`=0, `result_valid`=0, `illegal_o`=0. An in-flight op is discarded and produces no pulse.

## Timing
- Base op accepted at edge k: `result`/`result_valid` visible after edge k (latency 1). Back-to-back base ops sustain one per cycle.
- M op accepted at edge k: `ready_o` low after edge k. `result_valid` pulses after edge k+XLEN+1, and `ready_o` returns high in that same cycle (latency XLEN+2; 34 cycles for XLEN=32). A new op may be accepted in the pulse cycle.
- `result_valid` is never high for two consecutive cycles from a single op.

## Structure
- Shared package `alu_pkg`:
  - opcode localparams (OP, OP_IMM, LOAD, STORE, BRANCH, LUI, AUIPC);
  - funct7 constants (BASE, ALT, MULDIV);
  - `alu_op_t` enum covering the 10 base ops, 8 M ops and PASS_B;
  - FSM state enum.
- Sub-module `alu_op_decode`: combinational mapping of opcode/funct3/funct7 → {`alu_op_t`, is_m, illegal}. It replaces the old 4-bit control decoder.
- Top level holds the FSM, counter, iterative datapath and result register.

## Test plan
- Base op (XLEN=32): SRA with a=0x80000000, b=4 → result 0xF8000000, `result_valid` one cycle after accept. SLTU a=1, b=0xFFFFFFFF → 1. SLT on the same values → 0.
- MUL/MULH: a=0xFFFFFFFD (−3), b=7 → MUL 0xFFFFFFEB, MULH 0xFFFFFFFF, each exactly 34 cycles after accept. MULHU a=b=0xFFFFFFFF → 0xFFFFFFFE.
- Divide by zero: DIV 7/0 → 0xFFFFFFFF. REMU 7/0 → 7. DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM of the same → 0. DIV −7/2 → 0xFFFFFFFD. REM −7/2 → 0xFFFFFFFF.
- Handshake: hold `valid_i` high with ADD ops during a DIV → ADDs not accepted until the pulse cycle. Then ADD 1+2 and ADD 3+4 on consecutive cycles → results 3 and 7 on consecutive cycles.
- Reset mid-op: assert `reset` 10 cycles into a MULHU → next cycle `ready_o`=1, `result`=0. No `result_valid` for the next 40 cycles.
- Illegal: opcode 0x7F, a=5, b=6 → `result`=11, `illegal_o`=1 with `result_valid`. SLLI with funct7=0100000 → `illegal_o`=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the RV32IM execute unit: opcodes, funct7 codes,
// the decoded operation enum and the iterative-unit FSM states.
package alu_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND,
    ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
    ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU,
    ALU_PASS_B
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE, ST_LOAD, ST_BUSY, ST_FIX
  } mdu_state_t;

  function automatic logic op_is_mul(input alu_op_t op);
    return op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU};
  endfunction

  function automatic logic op_signed_a(input alu_op_t op);
    return op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM};
  endfunction

  function automatic logic op_signed_b(input alu_op_t op);
    return op inside {ALU_MUL, ALU_MULH, ALU_DIV, ALU_REM};
  endfunction

endpackage

// File: rtl/alu_mdu_if.sv
// Request/response bundle between the execute stage and alu_mdu.
interface alu_mdu_if #(
  parameter int unsigned XLEN = 32
);
  logic            valid_i;
  logic            ready_o;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [XLEN-1:0] result;
  logic            result_valid;
  logic            illegal_o;

  modport master (
    output valid_i, opcode, funct3, funct7, a, b,
    input  ready_o, result, result_valid, illegal_o
  );

  modport slave (
    input  valid_i, opcode, funct3, funct7, a, b,
    output ready_o, result, result_valid, illegal_o
  );
endinterface

// File: rtl/alu_op_decode.sv
// Combinational opcode/funct3/funct7 decode into an ALU/MDU operation.
// Undecodable encodings fall back to ADD with the illegal flag raised.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output alu_op_t    op,
  output logic       is_m,
  output logic       illegal
);

  always_comb begin
    op      = ALU_ADD;
    is_m    = 1'b0;
    illegal = 1'b0;
    case (opcode)
      OPC_OP: begin
        if (funct7 == F7_MULDIV) begin
          is_m = 1'b1;
          case (funct3)
            3'd0: op = ALU_MUL;
            3'd1: op = ALU_MULH;
            3'd2: op = ALU_MULHSU;
            3'd3: op = ALU_MULHU;
            3'd4: op = ALU_DIV;
            3'd5: op = ALU_DIVU;
            3'd6: op = ALU_REM;
            3'd7: op = ALU_REMU;
          endcase
        end else if (funct7 == F7_BASE) begin
          case (funct3)
            3'd0: op = ALU_ADD;
            3'd1: op = ALU_SLL;
            3'd2: op = ALU_SLT;
            3'd3: op = ALU_SLTU;
            3'd4: op = ALU_XOR;
            3'd5: op = ALU_SRL;
            3'd6: op = ALU_OR;
            3'd7: op = ALU_AND;
          endcase
        end else if (funct7 == F7_ALT && funct3 == 3'd0) begin
          op = ALU_SUB;
        end else if (funct7 == F7_ALT && funct3 == 3'd5) begin
          op = ALU_SRA;
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        case (funct3)
          3'd0: op = ALU_ADD;
          3'd1: begin
            if (funct7 == F7_BASE) op = ALU_SLL;
            else                   illegal = 1'b1;
          end
          3'd2: op = ALU_SLT;
          3'd3: op = ALU_SLTU;
          3'd4: op = ALU_XOR;
          3'd5: begin
            if (funct7 == F7_BASE)     op = ALU_SRL;
            else if (funct7 == F7_ALT) op = ALU_SRA;
            else                       illegal = 1'b1;
          end
          3'd6: op = ALU_OR;
          3'd7: op = ALU_AND;
        endcase
      end
      OPC_LOAD, OPC_STORE, OPC_AUIPC: op = ALU_ADD;
      OPC_BRANCH:                     op = ALU_SUB;
      OPC_LUI:                        op = ALU_PASS_B;
      default:                        illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_mdu.sv
// RV32IM execute unit: single-cycle base ALU plus an iterative
// multiply/divide engine that shares one 2*XLEN accumulator.
module alu_mdu
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic     clk,
  input  logic     reset,
  alu_mdu_if.slave bus
);

  localparam int unsigned SW = $clog2(XLEN);

  alu_op_t dec_op;
  logic    dec_is_m;
  logic    dec_illegal;

  alu_op_decode u_dec (
    .opcode  (bus.opcode),
    .funct3  (bus.funct3),
    .funct7  (bus.funct7),
    .op      (dec_op),
    .is_m    (dec_is_m),
    .illegal (dec_illegal)
  );

  mdu_state_t        state_q, state_d;
  logic [SW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  alu_op_t           op_q, op_d;
  logic              neg_q, neg_d;
  logic              rneg_q, rneg_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              result_valid_q, result_valid_d;
  logic              illegal_q, illegal_d;

  logic              ready;
  logic              accept;
  logic [SW-1:0]     shamt;
  logic [XLEN-1:0]   base_res;
  logic              a_neg, b_neg;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN-1:0]   acc_hi, acc_lo;
  logic [XLEN:0]     mul_sum, div_shift;
  logic              div_ge;
  logic [XLEN-1:0]   div_rem;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, mdu_res;

  assign accept = bus.valid_i && ready;
  assign acc_hi = acc_q[2*XLEN-1:XLEN];
  assign acc_lo = acc_q[XLEN-1:0];

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept && dec_is_m) state_d = ST_LOAD;
      ST_LOAD: state_d = ST_BUSY;
      ST_BUSY: if (cnt_q == '0) state_d = ST_FIX;
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ready = 1'b0;
    if (state_q == ST_IDLE) ready = 1'b1;
  end

  always_comb begin
    shamt    = bus.b[SW-1:0];
    base_res = bus.a + bus.b;
    case (dec_op)
      ALU_SUB:    base_res = bus.a - bus.b;
      ALU_SLL:    base_res = bus.a << shamt;
      ALU_SLT:    base_res = {{(XLEN-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
      ALU_SLTU:   base_res = {{(XLEN-1){1'b0}}, bus.a < bus.b};
      ALU_XOR:    base_res = bus.a ^ bus.b;
      ALU_SRL:    base_res = bus.a >> shamt;
      ALU_SRA:    base_res = $signed(bus.a) >>> shamt;
      ALU_OR:     base_res = bus.a | bus.b;
      ALU_AND:    base_res = bus.a & bus.b;
      ALU_PASS_B: base_res = bus.b;
      default:    ;
    endcase
  end

  // Operands are reduced to magnitudes at accept; signs are reapplied in FIX.
  always_comb begin
    a_neg = op_signed_a(dec_op) && bus.a[XLEN-1];
    b_neg = op_signed_b(dec_op) && bus.b[XLEN-1];
    mag_a = a_neg ? -bus.a : bus.a;
    mag_b = b_neg ? -bus.b : bus.b;
  end

  // Multiply shifts the product right through acc; divide shifts the
  // dividend left out of acc_lo while quotient bits enter at bit 0.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_q} : '0);
    div_shift = {acc_hi, acc_lo[XLEN-1]};
    div_ge    = div_shift >= {1'b0, opnd_q};
    div_rem   = div_ge ? (div_shift[XLEN-1:0] - opnd_q) : div_shift[XLEN-1:0];
  end

  always_comb begin
    prod = neg_q ? -acc_q : acc_q;
    quo  = (opnd_q == '0) ? '1 : (neg_q ? -acc_lo : acc_lo);
    rem  = rneg_q ? -acc_hi : acc_hi;
    case (op_q)
      ALU_MUL:                          mdu_res = prod[XLEN-1:0];
      ALU_MULH, ALU_MULHSU, ALU_MULHU:  mdu_res = prod[2*XLEN-1:XLEN];
      ALU_DIV, ALU_DIVU:                mdu_res = quo;
      default:                          mdu_res = rem;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    opnd_d = opnd_q;
    op_d   = op_q;
    neg_d  = neg_q;
    rneg_d = rneg_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && dec_is_m) begin
          op_d   = dec_op;
          neg_d  = a_neg ^ b_neg;
          rneg_d = a_neg;
          cnt_d  = SW'(XLEN - 1);
          if (op_is_mul(dec_op)) begin
            acc_d  = {{XLEN{1'b0}}, mag_b};
            opnd_d = mag_a;
          end else begin
            acc_d  = {{XLEN{1'b0}}, mag_a};
            opnd_d = mag_b;
          end
        end
      end
      ST_LOAD, ST_BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (op_is_mul(op_q)) acc_d = {mul_sum, acc_lo[XLEN-1:1]};
        else                 acc_d = {div_rem, acc_lo[XLEN-2:0], div_ge};
      end
      default: ;
    endcase
  end

  always_comb begin
    result_d       = result_q;
    result_valid_d = 1'b0;
    illegal_d      = 1'b0;
    if (accept && !dec_is_m) begin
      result_d       = base_res;
      result_valid_d = 1'b1;
      illegal_d      = dec_illegal;
    end else if (state_q == ST_FIX) begin
      result_d       = mdu_res;
      result_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q          <= '0;
      acc_q          <= '0;
      opnd_q         <= '0;
      op_q           <= ALU_ADD;
      neg_q          <= 1'b0;
      rneg_q         <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      illegal_q      <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      acc_q          <= acc_d;
      opnd_q         <= opnd_d;
      op_q           <= op_d;
      neg_q          <= neg_d;
      rneg_q         <= rneg_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      illegal_q      <= illegal_d;
    end
  end

  assign bus.ready_o      = ready;
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.illegal_o    = illegal_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Bench for alu_mdu: directed vector table, randomized ops against an
// arithmetic reference model, and handshake / reset-in-flight sequences.
module tb_alu_mdu;

  localparam int unsigned XLEN = 32;
  localparam logic [6:0] OP  = 7'h33;
  localparam logic [6:0] OPI = 7'h13;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_mdu_if #(.XLEN(XLEN)) bus ();
  alu_mdu #(.XLEN(XLEN)) dut (.clk(clk), .reset(reset), .bus(bus));

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    bit          chk_res;
    bit          ill;
    int          lat;
  } vec_t;

  vec_t vecs[19];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] a, input logic [31:0] b);
    bus.opcode = opc;
    bus.funct3 = f3;
    bus.funct7 = f7;
    bus.a      = a;
    bus.b      = b;
  endtask

  // Called at a negedge; returns at the negedge of the result_valid cycle.
  task automatic run_op(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic ill, output int lat);
    int w = 0;
    while (bus.ready_o !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("ready_before_op", bus.ready_o, 1);
    drive(opc, f3, f7, a, b);
    bus.valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.valid_i = 1'b0;
    lat = 1;
    while (bus.result_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    res = bus.result;
    ill = bus.illegal_o;
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  // RISC-V semantics written directly as 64-bit arithmetic.
  function automatic void ref_op(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                                 input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] res, output bit ill, output bit mop);
    longint          sa, sb;
    longint unsigned ua, ub;
    int              sh;
    bit              alt;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'h0, a};
    ub  = {32'h0, b};
    sh  = int'(b % 32);
    alt = (f7 == 7'h20);
    res = a + b;
    ill = 1'b0;
    mop = 1'b0;
    if (opc == OP && f7 == 7'h01) begin
      mop = 1'b1;
      case (f3)
        3'd0: res = 32'(sa * sb);
        3'd1: res = 32'((sa * sb) >>> 32);
        3'd2: res = 32'((sa * longint'(ub)) >>> 32);
        3'd3: res = 32'((ua * ub) >> 32);
        3'd4: if (b == 0) res = 32'hFFFF_FFFF;
              else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = a;
              else res = 32'(sa / sb);
        3'd5: if (b == 0) res = 32'hFFFF_FFFF; else res = 32'(ua / ub);
        3'd6: if (b == 0) res = a;
              else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = 32'h0;
              else res = 32'(sa % sb);
        3'd7: if (b == 0) res = a; else res = 32'(ua % ub);
      endcase
    end else begin
      if (opc == OPI && ((f3 == 3'd1 && f7 != 0) || (f3 == 3'd5 && f7 != 0 && !alt))) ill = 1'b1;
      case (f3)
        3'd0: res = (opc == OP && alt) ? a - b : a + b;
        3'd1: res = a << sh;
        3'd2: res = (sa < sb) ? 32'd1 : 32'd0;
        3'd3: res = (ua < ub) ? 32'd1 : 32'd0;
        3'd4: res = a ^ b;
        3'd5: res = alt ? 32'(sa >>> sh) : a >> sh;
        3'd6: res = a | b;
        3'd7: res = a & b;
      endcase
    end
  endfunction

  initial begin
    logic [31:0] r;
    logic        il;
    int          lat;
    int          n;
    int          early;
    int          pulses;

    vecs[0]  = '{OP,    3'd5, 7'h20, 32'h8000_0000, 32'd4,          32'hF800_0000, 1'b1, 1'b0, 1};
    vecs[1]  = '{OP,    3'd3, 7'h00, 32'd1,         32'hFFFF_FFFF,  32'd1,         1'b1, 1'b0, 1};
    vecs[2]  = '{OP,    3'd2, 7'h00, 32'd1,         32'hFFFF_FFFF,  32'd0,         1'b1, 1'b0, 1};
    vecs[3]  = '{OP,    3'd0, 7'h01, 32'hFFFF_FFFD, 32'd7,          32'hFFFF_FFEB, 1'b1, 1'b0, 34};
    vecs[4]  = '{OP,    3'd1, 7'h01, 32'hFFFF_FFFD, 32'd7,          32'hFFFF_FFFF, 1'b1, 1'b0, 34};
    vecs[5]  = '{OP,    3'd3, 7'h01, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'hFFFF_FFFE, 1'b1, 1'b0, 34};
    vecs[6]  = '{OP,    3'd4, 7'h01, 32'd7,         32'd0,          32'hFFFF_FFFF, 1'b1, 1'b0, 34};
    vecs[7]  = '{OP,    3'd7, 7'h01, 32'd7,         32'd0,          32'd7,         1'b1, 1'b0, 34};
    vecs[8]  = '{OP,    3'd4, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000, 1'b1, 1'b0, 34};
    vecs[9]  = '{OP,    3'd6, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF,  32'd0,         1'b1, 1'b0, 34};
    vecs[10] = '{OP,    3'd4, 7'h01, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 1'b1, 1'b0, 34};
    vecs[11] = '{OP,    3'd6, 7'h01, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 1'b1, 1'b0, 34};
    vecs[12] = '{7'h7F, 3'd0, 7'h00, 32'd5,         32'd6,          32'd11,        1'b1, 1'b1, 1};
    vecs[13] = '{OPI,   3'd1, 7'h20, 32'd3,         32'd4,          32'd0,         1'b0, 1'b1, 1};
    vecs[14] = '{7'h37, 3'd0, 7'h00, 32'd123,       32'hABCD_E000,  32'hABCD_E000, 1'b1, 1'b0, 1};
    vecs[15] = '{7'h63, 3'd0, 7'h00, 32'd10,        32'd3,          32'd7,         1'b1, 1'b0, 1};
    vecs[16] = '{OP,    3'd2, 7'h01, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 1'b1, 1'b0, 34};
    vecs[17] = '{OP,    3'd5, 7'h01, 32'hFFFF_FFFF, 32'd10,         32'h1999_9999, 1'b1, 1'b0, 34};
    vecs[18] = '{OPI,   3'd5, 7'h20, 32'hF000_0000, 32'h0000_0408,  32'hFFF0_0000, 1'b1, 1'b0, 1};

    reset       = 1'b1;
    bus.valid_i = 1'b0;
    drive(7'h0, 3'd0, 7'h0, 32'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset_ready", bus.ready_o, 1);
    check("reset_result", bus.result, 0);
    check("reset_valid", bus.result_valid, 0);
    check("reset_illegal", bus.illegal_o, 0);

    for (int i = 0; i < 19; i++) begin
      run_op(vecs[i].opc, vecs[i].f3, vecs[i].f7, vecs[i].a, vecs[i].b, r, il, lat);
      if (vecs[i].chk_res) check($sformatf("vec%0d_result", i), r, vecs[i].res);
      check($sformatf("vec%0d_illegal", i), il, vecs[i].ill);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
    end

    for (int i = 0; i < 150; i++) begin
      logic [6:0]  opc, f7;
      logic [2:0]  f3;
      logic [31:0] a, b, er;
      bit          eill, emop;
      int unsigned k;
      k  = $urandom_range(0, 23);
      a  = pick_val();
      b  = pick_val();
      if (k < 8) begin
        opc = OP;
        f3  = 3'(k);
        f7  = ((k == 0 || k == 5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      end else if (k < 16) begin
        opc = OP;
        f3  = 3'(k - 8);
        f7  = 7'h01;
      end else begin
        opc = OPI;
        f3  = 3'($urandom_range(0, 7));
        case ($urandom_range(0, 2))
          0:       f7 = 7'h00;
          1:       f7 = 7'h20;
          default: f7 = 7'($urandom_range(0, 127));
        endcase
      end
      ref_op(opc, f3, f7, a, b, er, eill, emop);
      run_op(opc, f3, f7, a, b, r, il, lat);
      if (!eill) check($sformatf("rnd%0d_result op=%0h f3=%0d f7=%0h a=%0h b=%0h", i, opc, f3, f7, a, b), r, er);
      check($sformatf("rnd%0d_illegal", i), il, eill);
      check($sformatf("rnd%0d_latency", i), lat, emop ? 34 : 1);
    end

    // DIV with an ADD held on the bus: ADD must wait for the pulse cycle.
    check("hs_ready_start", bus.ready_o, 1);
    drive(OP, 3'd4, 7'h01, 32'd100, 32'd7);
    bus.valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    drive(OP, 3'd0, 7'h00, 32'd1, 32'd2);
    n     = 1;
    early = 0;
    while (bus.result_valid !== 1'b1 && n < 100) begin
      if (bus.ready_o !== 1'b0) early++;
      @(negedge clk);
      n++;
    end
    check("hs_ready_low", early, 0);
    check("hs_div_latency", n, 34);
    check("hs_div_result", bus.result, 14);
    check("hs_ready_in_pulse", bus.ready_o, 1);
    @(negedge clk);
    drive(OP, 3'd0, 7'h00, 32'd3, 32'd4);
    check("hs_add1_valid", bus.result_valid, 1);
    check("hs_add1_result", bus.result, 3);
    @(negedge clk);
    bus.valid_i = 1'b0;
    check("hs_add2_valid", bus.result_valid, 1);
    check("hs_add2_result", bus.result, 7);
    @(negedge clk);
    check("hs_single_pulse", bus.result_valid, 0);
    check("hs_result_held", bus.result, 7);

    // Reset ten cycles into a MULHU discards it without a pulse.
    drive(OP, 3'd3, 7'h01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    bus.valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.valid_i = 1'b0;
    repeat (9) @(negedge clk);
    check("rst_busy_before", bus.ready_o, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_ready", bus.ready_o, 1);
    check("rst_result", bus.result, 0);
    check("rst_valid", bus.result_valid, 0);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.result_valid === 1'b1) pulses++;
    end
    check("rst_no_pulse", pulses, 0);

    run_op(OP, 3'd0, 7'h01, 32'd6, 32'd9, r, il, lat);
    check("post_rst_mul_result", r, 54);
    check("post_rst_mul_latency", lat, 34);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
